// File: rtl/architecture_pio_out.sv
// Avalon-MM parallel output port with DATA/SET/CLEAR/TOGGLE registers and an
// optional one-shot inverting pulse (build with ARCHITECTURE_PIO_PULSE_EN).
module architecture_pio_out #(
  parameter int WIDTH        = 4,
  parameter int PULSE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;
  localparam logic [2:0] ADDR_PULSE  = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  // Upper write-data bits are architecturally ignored.
  assign unused_wd = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data_out <= wd;
        ADDR_SET:    data_out <= data_out | wd;
        ADDR_CLEAR:  data_out <= data_out & ~wd;
        ADDR_TOGGLE: data_out <= data_out ^ wd;
        default:     ;
      endcase
    end
  end

`ifdef ARCHITECTURE_PIO_PULSE_EN
  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES);

  logic [WIDTH-1:0] pulse_mask;
  logic [15:0]      cnt;
  logic             busy;

  assign busy = (cnt != 16'd0);

  // A PULSE write wins over the expiry of a running pulse, so a retrigger on
  // the last active cycle keeps the old bits and extends them.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_mask <= '0;
      cnt        <= '0;
    end else if (wr && (address == ADDR_PULSE)) begin
      pulse_mask <= pulse_mask | wd;
      cnt        <= PULSE_LOAD;
    end else if (busy) begin
      cnt <= cnt - 16'd1;
      if (cnt == 16'd1) begin
        pulse_mask <= '0;
      end
    end
  end

  assign out_port = data_out ^ pulse_mask;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_out);
      ADDR_PULSE:  readdata = 32'(pulse_mask);
      ADDR_STATUS: readdata = {cnt, 15'd0, busy};
      default:     readdata = '0;
    endcase
  end
`else
  assign out_port = data_out;

  always_comb begin
    readdata = '0;
    if (address == ADDR_DATA) begin
      readdata = 32'(data_out);
    end
  end
`endif

endmodule

// File: tb/tb_architecture_pio_out.sv
// Self-checking bench for architecture_pio_out (WIDTH=4, PULSE_CYCLES=4); the
// reference model tracks the pulse as an absolute end cycle.
module tb_architecture_pio_out;

  localparam int WIDTH = 4;
  localparam int PC    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] m_data = '0;
  logic [WIDTH-1:0] m_mask = '0;
  int               now_c = 0;
  int               m_end = 0;

  always #5 clk = ~clk;

  architecture_pio_out #(.WIDTH(WIDTH), .PULSE_CYCLES(PC)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port)
  );

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    int c;
    c = (m_end > now_c) ? (m_end - now_c) : 0;
    case (a)
      3'd0: return 32'(m_data);
`ifdef ARCHITECTURE_PIO_PULSE_EN
      3'd4: return 32'(m_mask);
      3'd5: return (32'(c) << 16) | ((c != 0) ? 32'd1 : 32'd0);
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock with the given bus cycle; the model is advanced at the same edge.
  task automatic step(input bit w, input logic [2:0] a, input logic [31:0] d, input bit r);
    address = a; writedata = d; chipselect = w; write_n = ~w; reset = r;
    @(posedge clk);
    now_c++;
    if (r) begin
      m_data = '0; m_mask = '0; m_end = now_c;
    end else begin
`ifdef ARCHITECTURE_PIO_PULSE_EN
      if (w && a == 3'd4) begin
        m_mask = m_mask | d[WIDTH-1:0];
        m_end  = now_c + PC;
      end else if (now_c >= m_end) begin
        m_mask = '0;
      end
`endif
      if (w) begin
        case (a)
          3'd0: m_data = d[WIDTH-1:0];
          3'd1: m_data = m_data | d[WIDTH-1:0];
          3'd2: m_data = m_data & ~d[WIDTH-1:0];
          3'd3: m_data = m_data ^ d[WIDTH-1:0];
          default: ;
        endcase
      end
    end
    #1;
    chipselect = 1'b0; write_n = 1'b1; reset = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 3'd0, 32'hF, 1'b1);
    step(1'b0, 3'd0, 32'h0, 1'b1);
    checks++;
    if (out_port !== 4'h0) begin
      failures++; $display("FAIL reset_out got=%h exp=0", out_port);
    end
    address = 3'd0; #1;
    checks++;
    if (readdata !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", readdata);
    end
    address = 3'd5; #1;
    checks++;
    if (readdata !== 32'h0) begin
      failures++; $display("FAIL reset_status got=%h exp=0", readdata);
    end
  endtask

  task automatic test_data_ops();
    logic [2:0]  ta [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [31:0] td [5] = '{32'h5, 32'hA, 32'h3, 32'hF, 32'hFFFFFFF0};
    logic [3:0]  te [5] = '{4'h5, 4'hF, 4'hC, 4'h3, 4'h0};
    logic [2:0]  zr [5] = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ta[i], td[i], 1'b0);
      checks++;
      if (out_port !== te[i]) begin
        failures++; $display("FAIL data_op%0d got=%h exp=%h", i, out_port, te[i]);
      end
      address = 3'd0; #1;
      checks++;
      if (readdata !== 32'(te[i])) begin
        failures++; $display("FAIL data_read%0d got=%h exp=%h", i, readdata, 32'(te[i]));
      end
    end
    step(1'b1, 3'd0, 32'h9, 1'b0);
    step(1'b1, 3'd6, 32'hF, 1'b0);
    step(1'b1, 3'd7, 32'h0, 1'b0);
    checks++;
    if (out_port !== 4'h9) begin
      failures++; $display("FAIL ignored_wr got=%h exp=9", out_port);
    end
    for (int i = 0; i < 5; i++) begin
      address = zr[i]; #1;
      checks++;
      if (readdata !== 32'h0) begin
        failures++; $display("FAIL zero_read a=%0d got=%h exp=0", zr[i], readdata);
      end
    end
  endtask

  task automatic test_read_pre_edge();
    step(1'b1, 3'd0, 32'h2, 1'b0);
    address = 3'd0; writedata = 32'h7; chipselect = 1'b1; write_n = 1'b0; #1;
    checks++;
    if (readdata !== 32'h2) begin
      failures++; $display("FAIL pre_edge got=%h exp=2", readdata);
    end
    step(1'b1, 3'd0, 32'h7, 1'b0);
    address = 3'd0; #1;
    checks++;
    if (readdata !== 32'h7) begin
      failures++; $display("FAIL post_edge got=%h exp=7", readdata);
    end
  endtask

`ifdef ARCHITECTURE_PIO_PULSE_EN
  task automatic test_pulse();
    int c;
    step(1'b1, 3'd0, 32'h0, 1'b0);
    step(1'b1, 3'd4, 32'h1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      c = PC - i;
      checks++;
      if (out_port !== ((c != 0) ? 4'h1 : 4'h0)) begin
        failures++; $display("FAIL pulse_out i=%0d got=%h", i, out_port);
      end
      address = 3'd5; #1;
      checks++;
      if (readdata !== ((32'(c) << 16) | ((c != 0) ? 32'd1 : 32'd0))) begin
        failures++; $display("FAIL pulse_status i=%0d got=%h exp_cnt=%0d", i, readdata, c);
      end
      if (i < 4) step(1'b0, 3'd0, 32'h0, 1'b0);
    end
  endtask

  task automatic test_retrigger();
    step(1'b1, 3'd4, 32'h1, 1'b0);
    step(1'b0, 3'd0, 32'h0, 1'b0);
    step(1'b1, 3'd4, 32'h2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_port !== ((i < 4) ? 4'h3 : 4'h0)) begin
        failures++; $display("FAIL retrig_out i=%0d got=%h", i, out_port);
      end
      step(1'b0, 3'd0, 32'h0, 1'b0);
    end
    step(1'b1, 3'd4, 32'h0, 1'b0);
    address = 3'd5; #1;
    checks++;
    if (out_port !== 4'h0 || readdata !== 32'h0004_0001) begin
      failures++; $display("FAIL zero_pulse out=%h status=%h exp_status=00040001", out_port, readdata);
    end
    repeat (4) step(1'b0, 3'd0, 32'h0, 1'b0);
  endtask

  task automatic test_pulse_reset();
    step(1'b1, 3'd0, 32'h4, 1'b0);
    step(1'b1, 3'd4, 32'h4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_port !== ((i < 4) ? 4'h0 : 4'h4)) begin
        failures++; $display("FAIL pulse_inv i=%0d got=%h", i, out_port);
      end
      if (i < 4) step(1'b0, 3'd0, 32'h0, 1'b0);
    end
    step(1'b1, 3'd4, 32'h1, 1'b0);
    step(1'b1, 3'd1, 32'h2, 1'b0);
    address = 3'd5; #1;
    checks++;
    if (out_port !== 4'h7 || readdata !== 32'h0003_0001) begin
      failures++; $display("FAIL data_during_pulse out=%h status=%h exp out=7 status=00030001", out_port, readdata);
    end
    step(1'b0, 3'd0, 32'h0, 1'b1);
    address = 3'd5; #1;
    checks++;
    if (out_port !== 4'h0 || readdata !== 32'h0) begin
      failures++; $display("FAIL reset_mid_pulse out=%h status=%h exp=0", out_port, readdata);
    end
  endtask
`else
  task automatic test_pulse_disabled();
    step(1'b1, 3'd0, 32'h5, 1'b0);
    step(1'b1, 3'd4, 32'hF, 1'b0);
    checks++;
    if (out_port !== 4'h5) begin
      failures++; $display("FAIL nopulse_out got=%h exp=5", out_port);
    end
    address = 3'd4; #1;
    checks++;
    if (readdata !== 32'h0) begin
      failures++; $display("FAIL nopulse_rd4 got=%h exp=0", readdata);
    end
    address = 3'd5; #1;
    checks++;
    if (readdata !== 32'h0) begin
      failures++; $display("FAIL nopulse_rd5 got=%h exp=0", readdata);
    end
  endtask
`endif

  task automatic test_random();
    logic [2:0]  a, ra;
    logic [31:0] d;
    bit          w, r;
    step(1'b0, 3'd0, 32'h0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      a = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 63) == 0);
      d = $urandom;
      step(w, a, d, r);
      checks++;
      if (out_port !== (m_data ^ m_mask)) begin
        failures++; $display("FAIL rand_out n=%0d got=%h exp=%h", n, out_port, m_data ^ m_mask);
      end
      ra = 3'($urandom_range(0, 7));
      address = ra; #1;
      checks++;
      if (readdata !== exp_read(ra)) begin
        failures++; $display("FAIL rand_read n=%0d a=%0d got=%h exp=%h", n, ra, readdata, exp_read(ra));
      end
    end
  endtask

  initial begin
    test_reset();
    test_data_ops();
    test_read_pre_edge();
`ifdef ARCHITECTURE_PIO_PULSE_EN
    test_pulse();
    test_retrigger();
    test_pulse_reset();
`else
    test_pulse_disabled();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
